// File: rtl/cacc_dlv_pkg.sv
// Shared constants and width helper for the CACC delivery-buffer read responder.
package cacc_dlv_pkg;

  localparam int CACC_DBUF_WIDTH  = 512;
  localparam int CACC_DBUF_AWIDTH = 6;
  localparam int PD_LAYER_END     = CACC_DBUF_WIDTH;
  localparam int PD_W             = CACC_DBUF_WIDTH + 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/cacc_dlv_out_fifo.sv
// Flop-based sync FIFO holding delivered beats; depth need not be a power of two.
module cacc_dlv_out_fifo
  import cacc_dlv_pkg::*;
#(
  parameter int W     = PD_W,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = clog2(DEPTH);
  localparam int OW = clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [OW-1:0] occ;
  logic          do_push, do_pop;

  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      occ <= occ + OW'(do_push) - OW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (occ == OCC_FULL);
  assign empty = (occ == '0);

endmodule

// File: rtl/cacc_dbuf_rd_deliver.sv
// dbuf read responder: credit-guarded RAM reads, tag pipe aligned to RAM latency,
// output FIFO to SDP, plus entry-free and layer-done pulses.
module cacc_dbuf_rd_deliver
  import cacc_dlv_pkg::*;
#(
  parameter int DATA_W    = CACC_DBUF_WIDTH,
  parameter int AW        = CACC_DBUF_AWIDTH,
  parameter int RD_LAT    = 2,
  parameter int OUT_DEPTH = 4
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rst,
  input  logic              dbuf_rd_en,
  input  logic [AW-1:0]     dbuf_rd_addr,
  input  logic              dbuf_rd_layer_end,
  output logic              dbuf_rd_ready,
  output logic              ram_rd_en,
  output logic [AW-1:0]     ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              cacc2sdp_valid,
  output logic [DATA_W:0]   cacc2sdp_pd,
  input  logic              cacc2sdp_ready,
  output logic              dbuf_rd_free,
  output logic              dp2reg_rd_done
);

  localparam int CW = clog2(OUT_DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(OUT_DEPTH);

  logic            acc, pop, fifo_full, fifo_empty;
  logic [CW-1:0]   cnt;
  logic [RD_LAT:0] vld_pipe, end_pipe;
  logic [RD_LAT:1] vld_q, end_q;

  // cnt covers both in-flight reads and FIFO entries, so an accepted read
  // always has a FIFO slot waiting when its data returns.
  assign dbuf_rd_ready = (cnt < CNT_MAX);
  assign acc           = dbuf_rd_en & dbuf_rd_ready;
  assign pop           = cacc2sdp_valid & cacc2sdp_ready;
  assign ram_rd_en     = acc;
  assign ram_rd_addr   = dbuf_rd_addr;

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) cnt <= '0;
    else                cnt <= cnt + CW'(acc) - CW'(pop);
  end

  assign vld_pipe = {vld_q, acc};
  assign end_pipe = {end_q, dbuf_rd_layer_end};

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) vld_q <= '0;
    else                vld_q <= vld_pipe[RD_LAT-1:0];
  end

  always_ff @(posedge nvdla_core_clk) begin
    end_q <= end_pipe[RD_LAT-1:0];
  end

  cacc_dlv_out_fifo #(.W(DATA_W + 1), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk   (nvdla_core_clk),
    .rst   (nvdla_core_rst),
    .push  (vld_pipe[RD_LAT]),
    .wdata ({end_pipe[RD_LAT], ram_rd_data}),
    .pop   (pop),
    .rdata (cacc2sdp_pd),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cacc2sdp_valid = ~fifo_empty;

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      dbuf_rd_free   <= 1'b0;
      dp2reg_rd_done <= 1'b0;
    end else begin
      dbuf_rd_free   <= pop;
      dp2reg_rd_done <= pop & cacc2sdp_pd[DATA_W];
    end
  end

  a_no_overflow : assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
    !(vld_pipe[RD_LAT] && fifo_full && !pop));
  a_cnt_max : assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
    cnt <= CNT_MAX);
  a_cnt_underflow : assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
    !(pop && cnt == '0));

endmodule

// File: tb/tb_cacc_dbuf_rd_deliver.sv
// Scoreboard bench for cacc_dbuf_rd_deliver: accepted reads queue expected beats,
// a negedge monitor checks beats, pulses and ready against the bench's own occupancy.
module tb_cacc_dbuf_rd_deliver;
  import cacc_dlv_pkg::*;

  localparam int DW    = 512;
  localparam int AW    = 6;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int G_LAT [2] = '{1, 3};
  localparam int G_DEP [2] = '{3, 5};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0, le = 1'b0, sdp_rdy = 1'b1;
  logic [AW-1:0] addr = '0;
  logic          rdy, ram_en, vld, free, done;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic [DW:0]   pd;
  logic          en6 = 1'b0;
  logic [AW-1:0] addr6 = '0;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cacc_dbuf_rd_deliver #(.DATA_W(DW), .AW(AW), .RD_LAT(LAT), .OUT_DEPTH(DEPTH)) u_dut (
    .nvdla_core_clk    (clk),
    .nvdla_core_rst    (rst),
    .dbuf_rd_en        (en),
    .dbuf_rd_addr      (addr),
    .dbuf_rd_layer_end (le),
    .dbuf_rd_ready     (rdy),
    .ram_rd_en         (ram_en),
    .ram_rd_addr       (ram_addr),
    .ram_rd_data       (ram_data),
    .cacc2sdp_valid    (vld),
    .cacc2sdp_pd       (pd),
    .cacc2sdp_ready    (sdp_rdy),
    .dbuf_rd_free      (free),
    .dp2reg_rd_done    (done)
  );

  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    for (int i = 0; i < 16; i++) w[i*32 +: 32] = {8'(i), 2'b01, a, 16'h5A3C ^ 16'(i * 257)};
    return w;
  endfunction

  function automatic logic [15:0] small_word(input logic [AW-1:0] a);
    return {4'hA, a, ~a};
  endfunction

  // RAM model with a two-cycle read latency
  logic [AW-1:0] a_d1, a_d2;
  always @(posedge clk) begin
    if (ram_en) a_d1 <= ram_addr;
    a_d2 <= a_d1;
  end
  assign ram_data = ram_word(a_d2);

  int n_chk = 0, n_pass = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  task automatic check_pd(input string nm, input logic [DW:0] act, input logic [DW:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Scoreboard: every accepted request queues its expected beat
  logic [DW:0] sb_q [$];
  always @(negedge clk) begin
    if (!rst && en && rdy) sb_q.push_back({le, ram_word(addr)});
  end

  int occ = 0, max_occ = 0, free_cnt = 0, done_cnt = 0, pops = 0, drop_cnt = 0;
  int t_acc = -1, t_vld = -1, last_pop = -1;
  bit arm = 1'b0, prev_pop = 1'b0, prev_tag = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      occ = 0; prev_pop = 1'b0; prev_tag = 1'b0;
    end else begin
      check("free_pulse", int'(free), int'(prev_pop));
      check("done_pulse", int'(done), int'(prev_pop & prev_tag));
      check("rd_ready", int'(rdy), int'(occ < DEPTH));
      if (free) free_cnt++;
      if (done) done_cnt++;
      if (en && !rdy) drop_cnt++;
      if (arm && en && rdy && t_acc < 0) t_acc = cyc;
      if (arm && vld && t_vld < 0) t_vld = cyc;
      prev_pop = 1'b0;
      if (vld) begin
        if (sb_q.size() == 0) check("unexpected_beat", int'(vld), 0);
        else begin
          check_pd("pd", pd, sb_q[0]);
          if (sdp_rdy) begin
            prev_tag = sb_q[0][DW];
            prev_pop = 1'b1;
            void'(sb_q.pop_front());
            pops++;
            last_pop = cyc;
          end
        end
      end
      occ = occ + int'(en && rdy) - int'(vld && sdp_rdy);
      if (occ > max_occ) max_occ = occ;
    end
  end

  // Alternate builds: RD_LAT=1/OUT_DEPTH=3 and RD_LAT=3/OUT_DEPTH=5, 16-bit data
  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int L = G_LAT[g];
    logic          rdy_g, ren, vld_g, free_g, done_g;
    logic [AW-1:0] raddr;
    logic [15:0]   rdata;
    logic [16:0]   pd_g;
    logic [AW-1:0] ap [1:3];
    int first_acc = -1, first_vld = -1, last_vld = -1, nbeat = 0, drop = 0, nfree = 0, ndone = 0;

    always @(posedge clk) begin
      if (ren) ap[1] <= raddr;
      ap[2] <= ap[1];
      ap[3] <= ap[2];
    end
    assign rdata = small_word(ap[L]);

    cacc_dbuf_rd_deliver #(.DATA_W(16), .AW(AW), .RD_LAT(L), .OUT_DEPTH(G_DEP[g])) u_alt (
      .nvdla_core_clk    (clk),
      .nvdla_core_rst    (rst),
      .dbuf_rd_en        (en6),
      .dbuf_rd_addr      (addr6),
      .dbuf_rd_layer_end (1'b0),
      .dbuf_rd_ready     (rdy_g),
      .ram_rd_en         (ren),
      .ram_rd_addr       (raddr),
      .ram_rd_data       (rdata),
      .cacc2sdp_valid    (vld_g),
      .cacc2sdp_pd       (pd_g),
      .cacc2sdp_ready    (1'b1),
      .dbuf_rd_free      (free_g),
      .dp2reg_rd_done    (done_g)
    );

    always @(negedge clk) begin
      if (!rst) begin
        if (en6 && !rdy_g) drop++;
        if (en6 && rdy_g && first_acc < 0) first_acc = cyc;
        if (free_g) nfree++;
        if (done_g) ndone++;
        if (vld_g) begin
          if (first_vld < 0) first_vld = cyc;
          last_vld = cyc;
          check("t6_data", int'(pd_g), int'({1'b0, small_word(AW'(nbeat))}));
          nbeat++;
        end
      end
    end
  end

  task automatic send(input int base, input int n, input int le_at, input int maxc);
    int i = 0, c = 0;
    while (i < n && c < maxc) begin
      @(posedge clk); #1;
      en = 1'b1; addr = AW'(base + i); le = (i == le_at);
      @(negedge clk);
      if (rdy) i++;
      c++;
    end
    @(posedge clk); #1;
    en = 1'b0; le = 1'b0;
    check("send_accepted", i, n);
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((sb_q.size() != 0 || vld) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", int'(n < maxc), 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int i, c, nacc, bad;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", int'(vld), 0);
    check("rst_free", int'(free), 0);
    check("rst_done", int'(done), 0);
    check("rst_ready", int'(rdy), 1);

    // 1: 16-beat stream, SDP always ready
    arm = 1'b1; pops = 0; free_cnt = 0; drop_cnt = 0;
    send(0, 16, -1, 100);
    drain(100);
    arm = 1'b0;
    check("t1_latency", t_vld - t_acc, LAT + 1);
    check("t1_back_to_back", last_pop - t_vld, 15);
    check("t1_beats", pops, 16);
    check("t1_free_pulses", free_cnt, 16);
    check("t1_ready_held", drop_cnt, 0);

    // 2: SDP stalled, only OUT_DEPTH credits granted
    pops = 0; i = 0;
    @(posedge clk); #1 sdp_rdy = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      en = 1'b1; addr = AW'(16 + i);
      @(negedge clk);
      if (rdy) i++;
    end
    check("t2_accepted_stalled", i, DEPTH);
    check("t2_ready_low", int'(rdy), 0);
    c = 0;
    while (i < 10 && c < 100) begin
      @(posedge clk); #1;
      sdp_rdy = 1'b1; en = 1'b1; addr = AW'(16 + i);
      @(negedge clk);
      if (rdy) i++;
      c++;
    end
    @(posedge clk); #1 en = 1'b0;
    drain(100);
    check("t2_accepted", i, 10);
    check("t2_beats", pops, 10);

    // 3: beat 7 of 8 carries layer_end
    done_cnt = 0;
    send(40, 8, 6, 100);
    drain(100);
    check("t3_done_pulses", done_cnt, 1);

    // 4: random request/ready traffic
    pops = 0; nacc = 0; c = 0; max_occ = 0;
    while (nacc < 1000 && c < 20000) begin
      @(posedge clk); #1;
      en = 1'($urandom_range(0, 1));
      addr = AW'($urandom);
      le = ($urandom_range(0, 7) == 0);
      sdp_rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (en && rdy) nacc++;
      c++;
    end
    @(posedge clk); #1;
    en = 1'b0; le = 1'b0; sdp_rdy = 1'b1;
    drain(200);
    check("t4_accepted", nacc, 1000);
    check("t4_beats", pops, 1000);
    check("t4_occ_bound", int'(max_occ <= DEPTH), 1);

    // 5: reset with 2 beats in the FIFO and 2 reads in flight
    @(posedge clk); #1 sdp_rdy = 1'b0;
    send(30, 2, -1, 20);
    repeat (3) @(posedge clk);
    send(32, 2, -1, 20);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t5_valid_cleared", int'(vld), 0);
    check("t5_ready_restored", int'(rdy), 1);
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (vld || free) bad++;
    end
    check("t5_no_stale", bad, 0);
    @(posedge clk); #1 sdp_rdy = 1'b1;
    pops = 0;
    send(5, 1, -1, 20);
    drain(50);
    check("t5_new_beat", pops, 1);

    // 6: alternate latency/depth builds at full rate
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      en6 = 1'b1; addr6 = AW'(k);
    end
    @(posedge clk); #1 en6 = 1'b0;
    repeat (10) @(posedge clk);
    check("t6a_latency", g_cfg[0].first_vld - g_cfg[0].first_acc, G_LAT[0] + 1);
    check("t6a_back_to_back", g_cfg[0].last_vld - g_cfg[0].first_vld, 7);
    check("t6a_beats", g_cfg[0].nbeat, 8);
    check("t6a_free", g_cfg[0].nfree, 8);
    check("t6a_done", g_cfg[0].ndone, 0);
    check("t6a_ready_held", g_cfg[0].drop, 0);
    check("t6b_latency", g_cfg[1].first_vld - g_cfg[1].first_acc, G_LAT[1] + 1);
    check("t6b_back_to_back", g_cfg[1].last_vld - g_cfg[1].first_vld, 7);
    check("t6b_beats", g_cfg[1].nbeat, 8);
    check("t6b_free", g_cfg[1].nfree, 8);
    check("t6b_done", g_cfg[1].ndone, 0);
    check("t6b_ready_held", g_cfg[1].drop, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
